// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 write engine: FSM state encoding,
// default timing in iCLK cycles and the slow (clear/home) command codes.
package lcd_pkg;

    // 82000 cycles of clear/home wait needs 17 bits.
    localparam int TIMER_W = 17;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_EXEC  = 2'd3;

    localparam int unsigned DEF_EN_SETUP   = 2;
    localparam int unsigned DEF_EN_WIDTH   = 16;
    localparam int unsigned DEF_EXEC_SHORT = 2500;
    localparam int unsigned DEF_EXEC_LONG  = 82000;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;

    // Clear and return-home are the only commands with the long busy time.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR ||
                       data == CMD_HOME  ||
                       data == CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter used for every wait in the LCD write FSM.
// Ports: clk, rst_n (async low), load, load_value in; value, expired out.
module lcd_timer
    import lcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic [TIMER_W-1:0] value,
    output logic               expired
);

    // Loading N gives N cycles: the last one is the cycle showing 1.
    assign expired = (value <= TIMER_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - TIMER_W'(1);
        end
    end

endmodule

// File: rtl/lcd_write_engine.sv
// HD44780 single-byte write engine: setup, enable pulse, then busy wait.
// Ports: iCLK, iRST_N, iDATA, iRS, iStart in; oDone, LCD_DATA/RS/RW/EN out.
module lcd_write_engine
    import lcd_pkg::*;
#(
    parameter int unsigned EN_SETUP   = DEF_EN_SETUP,
    parameter int unsigned EN_WIDTH   = DEF_EN_WIDTH,
    parameter int unsigned EXEC_SHORT = DEF_EXEC_SHORT,
    parameter int unsigned EXEC_LONG  = DEF_EXEC_LONG
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iStart,
    output logic       oDone,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN
);

    logic [1:0]         state;
    logic               start_d;
    logic               start_det;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_din;
    logic [TIMER_W-1:0] tmr_value_unused;
    logic               tmr_expired;

    assign LCD_RW = 1'b0;

    // start_d resets high so a start held across reset release is ignored.
    assign start_det = iStart && !start_d && (state == ST_IDLE);

    lcd_timer u_timer (
        .clk        (iCLK),
        .rst_n      (iRST_N),
        .load       (tmr_load),
        .load_value (tmr_din),
        .value      (tmr_value_unused),
        .expired    (tmr_expired)
    );

    // LCD_DATA/LCD_RS hold the latched byte, so they select the busy time.
    always_comb begin
        tmr_load = 1'b0;
        tmr_din  = '0;
        case (state)
            ST_IDLE: begin
                if (start_det) begin
                    tmr_load = 1'b1;
                    tmr_din  = TIMER_W'(EN_SETUP);
                end
            end
            ST_SETUP: begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_din  = TIMER_W'(EN_WIDTH);
                end
            end
            ST_PULSE: begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_din  = is_slow_cmd(LCD_RS, LCD_DATA)
                             ? TIMER_W'(EXEC_LONG)
                             : TIMER_W'(EXEC_SHORT);
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= ST_IDLE;
            start_d  <= 1'b1;
            LCD_EN   <= 1'b0;
            LCD_DATA <= 8'h00;
            LCD_RS   <= 1'b0;
            oDone    <= 1'b0;
        end else begin
            start_d <= iStart;
            case (state)
                ST_IDLE: begin
                    if (start_det) begin
                        LCD_DATA <= iDATA;
                        LCD_RS   <= iRS;
                        oDone    <= 1'b0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_expired) begin
                        LCD_EN <= 1'b1;
                        state  <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (tmr_expired) begin
                        LCD_EN <= 1'b0;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (tmr_expired) begin
                        oDone <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_write_engine.sv
// Self-checking bench for lcd_write_engine against a transfer-timeline model.
// Directed scenarios followed by randomized start/data traffic.
module tb_lcd_write_engine;

    localparam int S  = 2;
    localparam int W  = 4;
    localparam int ES = 8;
    localparam int EL = 20;

    logic       iCLK = 1'b0;
    logic       iRST_N;
    logic [7:0] iDATA;
    logic       iRS;
    logic       iStart;
    logic       oDone;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;

    always #5 iCLK = ~iCLK;

    lcd_write_engine #(
        .EN_SETUP   (S),
        .EN_WIDTH   (W),
        .EXEC_SHORT (ES),
        .EXEC_LONG  (EL)
    ) dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .iDATA    (iDATA),
        .iRS      (iRS),
        .iStart   (iStart),
        .oDone    (oDone),
        .LCD_DATA (LCD_DATA),
        .LCD_RS   (LCD_RS),
        .LCD_RW   (LCD_RW),
        .LCD_EN   (LCD_EN)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: the last accepted transfer (start cycle + latched byte) and
    // the byte that was on the bus before it.
    bit         have       = 1'b0;
    int         t0         = 0;
    logic [7:0] lat_d      = 8'h00;
    logic       lat_rs     = 1'b0;
    logic [7:0] old_d      = 8'h00;
    logic       old_rs     = 1'b0;
    logic       prev_start = 1'b1;

    int   en_rises  = 0;
    int   en_first  = -1;
    int   done_rise = -1;
    logic en_q      = 1'b0;
    logic done_q    = 1'b0;

    function automatic int xfer_len(input logic rs, input logic [7:0] d);
        int e;
        e = (!rs && d >= 8'h01 && d <= 8'h03) ? EL : ES;
        return 1 + S + W + e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d",
                   tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model
    // with this cycle's inputs.
    task automatic tick();
        int         rel;
        int         tot;
        logic       e_en;
        logic       e_done;
        logic       e_rs;
        logic [7:0] e_d;
        @(negedge iCLK);
        if (!iRST_N) begin
            have       = 1'b0;
            old_d      = 8'h00;
            old_rs     = 1'b0;
            prev_start = 1'b1;
        end
        rel    = cyc - t0;
        tot    = have ? xfer_len(lat_rs, lat_d) : 0;
        e_en   = have && rel >= 1 + S && rel <= S + W;
        e_done = have && rel >= tot;
        e_d    = !have ? 8'h00 : (rel >= 1 ? lat_d : old_d);
        e_rs   = !have ? 1'b0 : (rel >= 1 ? lat_rs : old_rs);
        chk("lcd_en", LCD_EN, e_en);
        chk("done", oDone, e_done);
        chk("lcd_data", LCD_DATA, e_d);
        chk("lcd_rs", LCD_RS, e_rs);
        chk("lcd_rw", LCD_RW, 0);
        if (LCD_EN === 1'b1 && en_q !== 1'b1) begin
            en_rises++;
            en_first = cyc;
        end
        if (oDone === 1'b1 && done_q !== 1'b1) done_rise = cyc;
        en_q   = LCD_EN;
        done_q = oDone;
        if (iRST_N) begin
            if (iStart && !prev_start && (!have || rel >= tot)) begin
                old_d  = have ? lat_d : 8'h00;
                old_rs = have ? lat_rs : 1'b0;
                lat_d  = iDATA;
                lat_rs = iRS;
                have   = 1'b1;
                t0     = cyc;
            end
            prev_start = iStart;
        end
        @(posedge iCLK);
        #1;
        cyc++;
    endtask

    int s;
    int base;

    initial begin
        iRST_N = 1'b0;
        iStart = 1'b0;
        iRS    = 1'b0;
        iDATA  = 8'h00;
        repeat (3) tick();
        iRST_N = 1'b1;
        tick();

        // Data write 0x41
        iRS = 1'b1; iDATA = 8'h41; iStart = 1'b1;
        s = cyc; base = en_rises;
        repeat (20) tick();
        chk("wr_done_cycle", done_rise, s + 15);
        chk("wr_en_first", en_first, s + 3);
        chk("wr_en_pulses", en_rises - base, 1);

        // Clear command: long wait
        iStart = 1'b0; tick();
        iRS = 1'b0; iDATA = 8'h01; iStart = 1'b1; s = cyc;
        repeat (30) tick();
        chk("clr_done_cycle", done_rise, s + 27);

        // Function-set command: short wait
        iStart = 1'b0; tick();
        iRS = 1'b0; iDATA = 8'h38; iStart = 1'b1; s = cyc;
        repeat (20) tick();
        chk("fset_done_cycle", done_rise, s + 15);

        // Start toggled while busy
        iStart = 1'b0; tick();
        iRS = 1'b1; iDATA = 8'h5A; iStart = 1'b1;
        s = cyc; base = en_rises;
        repeat (4) tick();
        iStart = 1'b0; tick();
        iStart = 1'b1;
        repeat (25) tick();
        chk("busy_en_pulses", en_rises - base, 1);
        chk("busy_done_cycle", done_rise, s + 15);
        chk("busy_done_held", oDone, 1);

        // Start held high
        iStart = 1'b0; tick();
        iRS = 1'b1; iDATA = 8'h30; iStart = 1'b1; base = en_rises;
        repeat (40) tick();
        chk("held_en_pulses", en_rises - base, 1);
        iStart = 1'b0; tick();
        iStart = 1'b1; s = cyc;
        tick();
        chk("held_done_low", oDone, 0);
        repeat (20) tick();
        chk("held_en_pulses2", en_rises - base, 2);
        chk("held_done_cycle", done_rise, s + 15);

        // Reset during the enable pulse
        iStart = 1'b0; tick();
        iRS = 1'b1; iDATA = 8'hC3; iStart = 1'b1;
        repeat (4) tick();
        chk("rst_pre_en", LCD_EN, 1);
        iRST_N = 1'b0;
        #1;
        chk("rst_en", LCD_EN, 0);
        chk("rst_done", oDone, 0);
        chk("rst_data", LCD_DATA, 8'h00);
        base = en_rises;
        repeat (2) tick();
        iRST_N = 1'b1;
        repeat (10) tick();
        chk("rst_no_xfer", en_rises - base, 0);
        chk("rst_no_done", oDone, 0);
        iStart = 1'b0; tick();
        iStart = 1'b1; s = cyc;
        repeat (20) tick();
        chk("rst_after_done", done_rise, s + 15);

        // Data changes mid-transfer
        iStart = 1'b0; tick();
        iRS = 1'b1; iDATA = 8'h41; iStart = 1'b1; s = cyc;
        repeat (2) tick();
        iDATA = 8'h55;
        repeat (13) tick();
        chk("chg_data", LCD_DATA, 8'h41);
        chk("chg_done", oDone, 1);

        // Random traffic
        iStart = 1'b0; tick();
        repeat (600) begin
            if ($urandom_range(0, 9) < 3) iStart = ~iStart;
            iRS = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                iDATA = 8'($urandom_range(1, 3));
            else
                iDATA = 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_write_engine.md
LCD_WRITE_ENGINE -- requirements
Module: lcd_write_engine

Interface
REQ-001 Parameter EN_SETUP, default 2: iCLK cycles that RS/DATA are stable before LCD_EN rises.
REQ-002 Parameter EN_WIDTH, default 16: iCLK cycles that LCD_EN is high.
REQ-003 Parameter EXEC_SHORT, default 2500: post-pulse wait for ordinary commands and data (50 us at 50 MHz).
REQ-004 Parameter EXEC_LONG, default 82000: post-pulse wait for clear/home commands (1.64 ms at 50 MHz).
REQ-005 iCLK  in  1  single clock for the block.
REQ-006 iRST_N  in  1  asynchronous, active-low reset.
REQ-007 iDATA  in  8  byte to write (command or character code).
REQ-008 iRS  in  1  register select: 0 = command, 1 = data.
REQ-009 iStart  in  1  request; a rising edge starts one transfer.
REQ-010 oDone  out  1  high from completion of a transfer until the next accepted start.
REQ-011 LCD_DATA  out  8  HD44780 data bus.
REQ-012 LCD_RS  out  1  HD44780 register select.
REQ-013 LCD_RW  out  1  HD44780 read/write, tied to 0 (write only).
REQ-014 LCD_EN  out  1  HD44780 enable strobe.

Function
REQ-015 The block SHALL register iStart into iStart_d each cycle; a start is detected when iStart=1, iStart_d=0 and the FSM is in IDLE.
REQ-016 The FSM SHALL have the states IDLE, SETUP, PULSE and EXEC, plus an internal timer counter of at least 17 bits.
REQ-017 On the detect cycle, the block SHALL latch iDATA and iRS, clear oDone, load the timer with EN_SETUP and enter SETUP on the next edge.
REQ-018 In SETUP, LCD_DATA and LCD_RS SHALL drive the latched values with LCD_EN=0; when the timer expires, the FSM SHALL go to PULSE and load EN_WIDTH.
REQ-019 In PULSE, LCD_EN SHALL be 1 for exactly EN_WIDTH cycles; the FSM SHALL then go to EXEC with LCD_EN=0.
REQ-020 EXEC SHALL last EXEC_LONG cycles when latched RS=0 and latched DATA is in {0x01, 0x02, 0x03}, and EXEC_SHORT cycles otherwise.
REQ-021 At EXEC expiry, the FSM SHALL return to IDLE and set oDone=1.
REQ-022 Latency from the detect cycle to oDone high SHALL be 1+EN_SETUP+EN_WIDTH+EXEC cycles.
REQ-023 LCD_DATA and LCD_RS SHALL hold the latched values from SETUP until the next accepted start, including through EXEC and IDLE.
REQ-024 Changes on iDATA/iRS outside the detect cycle SHALL have no effect on the bus.
REQ-025 Rising edges of iStart outside IDLE SHALL be ignored, not queued.
REQ-026 If iStart is held high, the block SHALL NOT start again; a new transfer needs iStart low for at least one cycle, then high.
REQ-027 A start detected in the same cycle that the FSM enters IDLE from EXEC SHALL NOT be accepted; acceptance begins the following cycle.

Reset
REQ-028 While iRST_N=0, asynchronously: state=IDLE, LCD_EN=0, LCD_DATA=0x00, LCD_RS=0, oDone=0, timer=0.
REQ-029 iStart_d SHALL reset to 1, so that an iStart held high across reset release does not start a transfer.
REQ-030 Reset asserted mid-transfer SHALL drop LCD_EN immediately and abandon the transfer; oDone SHALL NOT be asserted for it.

Structure
REQ-031 Package lcd_pkg SHALL hold the FSM state encoding, the default timing constants and the clear/home command codes.
REQ-032 One sub-module, lcd_timer, SHALL be used: a loadable down-counter with load, value and an expired flag; all waits in the FSM SHALL use it.

Verification (EN_SETUP=2, EN_WIDTH=4, EXEC_SHORT=8, EXEC_LONG=20)
REQ-033 Data write: iRS=1, iDATA=0x41, iStart rises at cycle 0.
  -> LCD_DATA=0x41 and LCD_RS=1 from cycle 1.
  -> LCD_EN high in cycles 3-6 only.
  -> oDone high at cycle 15.
REQ-034 Clear command: iRS=0, iDATA=0x01 -> oDone high at cycle 27; the same bench with iDATA=0x38 -> oDone high at cycle 15.
REQ-035 Busy start: iStart toggles low/high at cycles 4-5 during a transfer.
  -> exactly one EN pulse.
  -> oDone high at cycle 15, and stays high afterwards.
REQ-036 Held start: iStart held high for 40 cycles -> one transfer only; then drop iStart and raise it -> oDone falls on the cycle after detection and a second EN pulse follows.
REQ-037 Reset in PULSE: iRST_N low at cycle 4 with iStart held high.
  -> LCD_EN=0, oDone=0 and LCD_DATA=0x00 immediately.
  -> after release, no transfer occurs until iStart goes low then high.
REQ-038 Data change in flight: iDATA changes to 0x55 at cycle 2 of a 0x41 write -> LCD_DATA stays 0x41 through oDone.
